pc: RTL and testbench

4-bit program counter for the 4-bit CPU. It holds the address of the current instruction. On each rising clock edge it either loads an externally supplied start/jump address or advances by one. It sits between the control unit, which drives `set_pc` and `PC_INIT`, and instruction memory, which consumes `PC_CURR` as its read address.

---
 rtl/pc_pkg.sv | 14 +
 rtl/pc.sv | 42 ++++
 tb/tb_pc.sv | 119 +++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared CPU constants for the program counter.
// This package holds the address width, the reset vector, and the next-value select encoding.
package pc_pkg;

  localparam int unsigned           PC_WIDTH = 4;
  localparam logic [PC_WIDTH-1:0]   PC_RESET = '0;

  // Source of the next program counter value.
  typedef enum logic {
    PC_SEL_INC  = 1'b0,
    PC_SEL_LOAD = 1'b1
  } pc_sel_e;

endpackage : pc_pkg

// File: rtl/pc.sv
// Program counter for the 4-bit CPU.
// Each cycle it either loads a jump/start address or advances by one; the output comes straight from a flop.
module pc
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = PC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] PC_INIT,
  input  logic             set_pc,
  output logic [WIDTH-1:0] PC_CURR
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  pc_sel_e          sel;

  // Load wins over increment. The incrementer wraps at 2^WIDTH because its result is truncated.
  // NOTE: assign every always_comb output a default first so that no latch is inferred.
  always_comb begin
    sel  = set_pc ? PC_SEL_LOAD : PC_SEL_INC;
    pc_d = pc_q + WIDTH'(1);
    unique case (sel)
      PC_SEL_LOAD: pc_d = PC_INIT;
      PC_SEL_INC:  pc_d = pc_q + WIDTH'(1);
      default:     pc_d = pc_q + WIDTH'(1);
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= WIDTH'(PC_RESET);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign PC_CURR = pc_q;

endmodule : pc

// File: tb/tb_pc.sv
// Self-checking bench for pc.
// Directed test-plan cases are followed by randomized load/increment/reset traffic, all checked against an integer model.
module tb_pc;

  logic       clk;
  logic       rst_n;
  logic [3:0] pc_init;
  logic       set_pc;
  logic [3:0] pc_curr;

  int n_checks;
  int n_errors;
  int model_pc;  // reference value, 0..15

  pc dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .PC_INIT (pc_init),
    .set_pc  (set_pc),
    .PC_CURR (pc_curr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // This task is called just after a falling edge. It drives the inputs, lets one rising edge pass, then checks at the next falling edge.
  task automatic step(input string tag, input logic sp, input logic [3:0] init);
    set_pc  = sp;
    pc_init = init;
    @(posedge clk);
    if (rst_n) model_pc = sp ? int'(init) : (model_pc + 1) % 16;
    else       model_pc = 0;
    @(negedge clk);
    check(tag, pc_curr, 4'(model_pc));
  endtask

  // This task asserts reset in the middle of the low phase, well before the next rising edge.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    model_pc = 0;
    #1 check(tag, pc_curr, 4'(model_pc));
  endtask

  task automatic release_reset();
    rst_n = 1'b1;  // deasserted on a falling edge, so it is synchronous to clk
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_pc = 0;
    rst_n    = 1'b1;
    set_pc   = 1'b0;
    pc_init  = '0;

    // 1: async reset with no clock edge
    @(negedge clk);
    async_reset("reset_async");
    @(negedge clk);
    release_reset();

    // 2: load zero, then increment
    step("load_zero", 1'b1, 4'h0);
    step("inc_from_zero", 1'b0, 4'h9);

    // 3: load 5, count 6,7,8
    step("load_5", 1'b1, 4'h5);
    for (int i = 0; i < 3; i++) step("count_after_5", 1'b0, 4'h0);

    // 4: wrap E,F,0
    step("load_E", 1'b1, 4'hE);
    step("inc_to_F", 1'b0, 4'h3);
    step("wrap_to_0", 1'b0, 4'h3);

    // 5: reload priority while counting at 3
    step("load_2", 1'b1, 4'h2);
    step("count_3", 1'b0, 4'h0);
    step("reload_A", 1'b1, 4'hA);
    step("reload_C", 1'b1, 4'hC);

    // 6: reset mid-count at 7
    step("load_6", 1'b1, 4'h6);
    step("count_7", 1'b0, 4'h0);
    async_reset("reset_mid_count");
    step("hold_in_reset_1", 1'b1, 4'hB);
    step("hold_in_reset_2", 1'b0, 4'hB);
    release_reset();
    step("inc_after_reset", 1'b0, 4'h0);

    // The randomized phase below mixes loads, increments and occasional async resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        async_reset("rand_reset");
        step("rand_in_reset", 1'($urandom), 4'($urandom));
        release_reset();
      end else begin
        step("rand_step", ($urandom_range(0, 3) == 0), 4'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pc
